// File: rtl/chunked_multicycle_adder.sv
// -----------------------------------------------------------------------------
// chunked_multicycle_adder
//
// Multi-cycle adder/subtractor. One CHUNK-bit slice is added per clock, LSB
// first, and the ripple carry is kept in a register between slices. The
// combinational carry chain is therefore CHUNK bits long for any WIDTH.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands A/B/Cin/Sub are presented
//   in_ready   block is idle and can accept operands
//   A, B       WIDTH-bit operands
//   Cin        carry-in when adding, borrow-in when subtracting
//   Sub        0 = A + B + Cin, 1 = A - B - Cin
//   out_valid  Out/Cout/Ovf hold a finished result
//   out_ready  consumer accepts the result
//   Out        WIDTH-bit result (modulo 2^WIDTH)
//   Cout       carry out of bit WIDTH-1 (for subtract: 1 = no borrow)
//   Ovf        two's-complement overflow
// -----------------------------------------------------------------------------
module chunked_multicycle_adder #(
  parameter int WIDTH  = 32,
  parameter int CHUNK  = 8,
  parameter int NCHUNK = WIDTH / CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Cout,
  output logic             Ovf
);

  // Elaboration-time parameter sanity checks. The modulo guard avoids a
  // division by zero when CHUNK itself is illegal.
  if ((CHUNK < 1) || ((WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0)) begin : gBadChunk
    $error("chunked_multicycle_adder: WIDTH must be a positive multiple of CHUNK");
  end

  if ((CHUNK >= 1) && (NCHUNK != WIDTH / ((CHUNK < 1) ? 1 : CHUNK))) begin : gBadNchunk
    $error("chunked_multicycle_adder: NCHUNK must equal WIDTH/CHUNK");
  end

  // Slice counter needs at least one bit even when there is a single slice.
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] LAST_SLICE = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           stateQ, stateD;
  logic [WIDTH-1:0] opAQ, opAD;
  logic [WIDTH-1:0] opBQ, opBD;
  logic [WIDTH-1:0] outQ, outD;
  logic             carryQ, carryD;
  logic             coutQ, coutD;
  logic             ovfQ, ovfD;
  logic [KW-1:0]    kQ, kD;

  logic [CHUNK-1:0] sliceA;
  logic [CHUNK-1:0] sliceB;
  logic [CHUNK:0]   sliceSum;
  logic             msbCarryIn;

  // Slice adder. The sum is formed in a CHUNK+1 bit temporary so the top bit
  // is the carry out of the slice. On the last slice the carry into the MSB
  // is recovered from the MSB sum bit: s = a ^ b ^ cin  =>  cin = s ^ a ^ b.
  always_comb begin
    sliceA     = opAQ[kQ*CHUNK +: CHUNK];
    sliceB     = opBQ[kQ*CHUNK +: CHUNK];
    sliceSum   = {1'b0, sliceA} + {1'b0, sliceB} + {{CHUNK{1'b0}}, carryQ};
    msbCarryIn = sliceSum[CHUNK-1] ^ sliceA[CHUNK-1] ^ sliceB[CHUNK-1];
  end

  // Next-state and handshake logic. Subtraction is A + ~B + ~borrow, so the
  // operand is inverted at capture time and the initial carry is Cin ^ Sub.
  // Result slices are written straight into the output register; it is only
  // presented (out_valid) once every slice is done.
  always_comb begin
    stateD    = stateQ;
    opAD      = opAQ;
    opBD      = opBQ;
    outD      = outQ;
    carryD    = carryQ;
    coutD     = coutQ;
    ovfD      = ovfQ;
    kD        = kQ;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (stateQ)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          opAD   = A;
          opBD   = Sub ? ~B : B;
          carryD = Cin ^ Sub;
          kD     = '0;
          stateD = RUN;
        end
      end

      RUN: begin
        outD[kQ*CHUNK +: CHUNK] = sliceSum[CHUNK-1:0];
        carryD                  = sliceSum[CHUNK];
        if (kQ == LAST_SLICE) begin
          coutD  = sliceSum[CHUNK];
          ovfD   = msbCarryIn ^ sliceSum[CHUNK];
          stateD = DONE;
        end else begin
          kD = kQ + 1'b1;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          stateD = IDLE;
        end
      end

      default: begin
        stateD = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= IDLE;
      opAQ   <= '0;
      opBQ   <= '0;
      outQ   <= '0;
      carryQ <= 1'b0;
      coutQ  <= 1'b0;
      ovfQ   <= 1'b0;
      kQ     <= '0;
    end else begin
      stateQ <= stateD;
      opAQ   <= opAD;
      opBQ   <= opBD;
      outQ   <= outD;
      carryQ <= carryD;
      coutQ  <= coutD;
      ovfQ   <= ovfD;
      kQ     <= kD;
    end
  end

  assign Out  = outQ;
  assign Cout = coutQ;
  assign Ovf  = ovfQ;

endmodule

// File: tb/tb_chunked_multicycle_adder.sv
// -----------------------------------------------------------------------------
// tb_chunked_multicycle_adder
//
// Scoreboard bench for chunked_multicycle_adder. The driver pushes the
// expected {Ovf, Cout, Out} and the accept cycle for every accepted operation;
// a separate monitor pops and compares on each output handshake, and also
// checks latency, output stability under backpressure and in_ready in DONE.
// The reference model works on plain integers (A +/- B +/- carry and a signed
// range test), not on slices.
// -----------------------------------------------------------------------------
module tb_chunked_multicycle_adder;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ovf;
    int               acceptCycle;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] aIn;
  logic [WIDTH-1:0] bIn;
  logic             cinIn;
  logic             subIn;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] outRes;
  logic             coutRes;
  logic             ovfRes;

  exp_t sbQ[$];
  int   testsRun;
  int   testsFailed;
  int   cycle;
  int   readyMode;  // 0 = hold low, 1 = hold high, 2 = random

  chunked_multicycle_adder #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .A         (aIn),
    .B         (bIn),
    .Cin       (cinIn),
    .Sub       (subIn),
    .out_valid (outValid),
    .out_ready (outReady),
    .Out       (outRes),
    .Cout      (coutRes),
    .Ovf       (ovfRes)
  );

  // Free-running clock and a cycle count used for latency measurement.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Consumer: out_ready changes just after each rising edge.
  initial begin
    outReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       outReady = 1'b0;
        1:       outReady = 1'b1;
        default: outReady = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Single comparison point: counts every check and reports failures.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: integer arithmetic on the operands, overflow as a signed
  // range test. Returns {ovf, cout, out}.
  function automatic logic [WIDTH+1:0] refModel(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic cin, input logic sub);
    longint ua, ub, sa, sb, c, u, s, maxS, minS;
    logic   co, ov;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    c    = cin ? 64'sd1 : 64'sd0;
    maxS = (64'sd1 <<< (WIDTH - 1)) - 64'sd1;
    minS = -(64'sd1 <<< (WIDTH - 1));
    if (sub) begin
      u  = ua - ub - c;
      s  = sa - sb - c;
      co = (u >= 0);
    end else begin
      u  = ua + ub + c;
      s  = sa + sb + c;
      co = (u >= (64'sd1 <<< WIDTH));
    end
    ov = (s > maxS) || (s < minS);
    return {ov, co, u[WIDTH-1:0]};
  endfunction

  // Driver: present operands at a falling edge, wait (bounded) for in_ready,
  // record the expectation for the accepting edge, then scramble the inputs.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic sub,
                               input bit useConst, input logic [WIDTH+1:0] constExp);
    exp_t             e;
    logic [WIDTH+1:0] r;
    int               waitCnt;
    @(negedge clk);
    inValid = 1'b1;
    aIn     = a;
    bIn     = b;
    cinIn   = cin;
    subIn   = sub;
    waitCnt = 0;
    while (!inReady && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!inReady) begin
      checkOutput("accept timeout", 64'(inReady), 64'd1);
      inValid = 1'b0;
      return;
    end
    r             = useConst ? constExp : refModel(a, b, cin, sub);
    e.out         = r[WIDTH-1:0];
    e.cout        = r[WIDTH];
    e.ovf         = r[WIDTH+1];
    e.acceptCycle = cycle + 1;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    aIn     = $urandom();
    bIn     = $urandom();
    cinIn   = 1'($urandom_range(0, 1));
    subIn   = 1'($urandom_range(0, 1));
  endtask

  // Monitor: at each falling edge, check latency on out_valid rise, output
  // stability while held, in_ready low in DONE, and compare on handshake.
  initial begin
    bit               prevValid;
    bit               prevHeld;
    logic [WIDTH+1:0] prevOut;
    exp_t             e;
    prevValid = 1'b0;
    prevHeld  = 1'b0;
    prevOut   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevValid = 1'b0;
        prevHeld  = 1'b0;
        continue;
      end
      if (outValid) begin
        if (sbQ.size() == 0) begin
          if (!prevValid) checkOutput("unexpected out_valid", 64'(outValid), 64'd0);
        end else begin
          if (!prevValid)
            checkOutput("latency", 64'(cycle - sbQ[0].acceptCycle), 64'(NCHUNK));
          if (prevHeld)
            checkOutput("hold stable", 64'({ovfRes, coutRes, outRes}), 64'(prevOut));
          checkOutput("in_ready in DONE", 64'(inReady), 64'd0);
          if (outReady) begin
            e = sbQ.pop_front();
            checkOutput("Out", 64'(outRes), 64'(e.out));
            checkOutput("Cout", 64'(coutRes), 64'(e.cout));
            checkOutput("Ovf", 64'(ovfRes), 64'(e.ovf));
            prevHeld = 1'b0;
          end else begin
            prevHeld = 1'b1;
            prevOut  = {ovfRes, coutRes, outRes};
          end
        end
      end else begin
        prevHeld = 1'b0;
      end
      prevValid = outValid;
    end
  end

  // Bounded wait for the scoreboard to empty.
  task automatic waitDrain(input string name);
    int guard;
    guard = 0;
    while (sbQ.size() != 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput(name, 64'(sbQ.size()), 64'd0);
  endtask

  // Hard time limit so the bench always ends.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence: reset, directed vectors, backpressure, mid-run reset,
  // then randomized operations with random consumer backpressure.
  initial begin
    int               guard;
    bit               sawValid;
    logic [63:0]      r64;
    logic [WIDTH-1:0] ra, rb;
    testsRun    = 0;
    testsFailed = 0;
    readyMode   = 1;
    rst_n       = 1'b1;
    inValid     = 1'b0;
    aIn         = '0;
    bIn         = '0;
    cinIn       = 1'b0;
    subIn       = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset in_ready", 64'(inReady), 64'd1);
    checkOutput("reset out_valid", 64'(outValid), 64'd0);
    checkOutput("reset Out", 64'(outRes), 64'd0);
    checkOutput("reset Cout/Ovf", 64'({coutRes, ovfRes}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-computed results {Ovf, Cout, Out}.
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, {1'b0, 1'b1, 32'h0000_0000});
    applyStimulus(32'd5, 32'd7, 1'b0, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
    applyStimulus(32'd7, 32'd5, 1'b0, 1'b1, 1'b1, {1'b0, 1'b1, 32'h0000_0002});
    applyStimulus(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, {1'b1, 1'b0, 32'h8000_0000});
    applyStimulus(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
    applyStimulus(32'd7, 32'd5, 1'b1, 1'b1, 1'b1, {1'b0, 1'b1, 32'h0000_0001});
    applyStimulus(32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, {1'b0, 1'b0, 32'h0000_0100});
    waitDrain("directed drain");

    // Backpressure: hold the result for 10 cycles and try to push new operands.
    readyMode = 0;
    applyStimulus(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b1, {1'b0, 1'b0, 32'h2143_6587});
    guard = 0;
    while (!outValid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("backpressure out_valid", 64'(outValid), 64'd1);
    inValid = 1'b1;
    aIn     = 32'd1;
    bIn     = 32'd1;
    cinIn   = 1'b0;
    subIn   = 1'b0;
    repeat (10) begin
      @(negedge clk);
      checkOutput("busy in_ready", 64'(inReady), 64'd0);
    end
    inValid   = 1'b0;
    readyMode = 1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("out_valid drop", 64'(outValid), 64'd0);
    checkOutput("in_ready back", 64'(inReady), 64'd1);
    checkOutput("Out kept after handshake", 64'({ovfRes, coutRes, outRes}),
                64'({1'b0, 1'b0, 32'h2143_6587}));
    checkOutput("ignored op dropped", 64'(sbQ.size()), 64'd0);

    // Reset while slice 2 of an operation is being added.
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1, {1'b0, 1'b0, 32'h2345_6789});
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    sbQ.delete();
    checkOutput("midrun reset Out", 64'(outRes), 64'd0);
    checkOutput("midrun reset Cout/Ovf", 64'({coutRes, ovfRes}), 64'd0);
    checkOutput("midrun reset out_valid", 64'(outValid), 64'd0);
    checkOutput("midrun reset in_ready", 64'(inReady), 64'd1);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    sawValid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (outValid) sawValid = 1'b1;
    end
    checkOutput("no result after reset", 64'(sawValid), 64'd0);
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1, {1'b0, 1'b0, 32'h2345_6789});
    waitDrain("post reset drain");

    // Randomized operations, edge values mixed in, random out_ready.
    readyMode = 2;
    for (int i = 0; i < 400; i++) begin
      r64 = {$urandom(), $urandom()};
      ra  = r64[WIDTH-1:0];
      r64 = {$urandom(), $urandom()};
      rb  = r64[WIDTH-1:0];
      case ($urandom_range(0, 7))
        0: ra = '1;
        1: rb = {1'b1, {(WIDTH-1){1'b0}}};
        2: ra = {1'b0, {(WIDTH-1){1'b1}}};
        3: rb = '0;
        default: ;
      endcase
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    readyMode = 1;
    waitDrain("random drain");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
